// File: rtl/pe_result_writer.sv
// Serializes P-element PE result vectors into one-element-per-cycle main-memory writes at sequential addresses.
// Latency: element 0 one cycle after the vector handshake; store_done one cycle after the last write.
// Backpressure: pe_ready only in WAIT_VEC; RESULT_WRITER_SKID_EN adds a one-vector skid so pe_ready may also rise in WRITE.
module pe_result_writer #(
    parameter int FEATURE_BITS = 4,
    parameter int ELEMENT_BITS = 8,
    parameter int P            = 4
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2*FEATURE_BITS-1:0]     base_address,
    input  logic [2*FEATURE_BITS-1:0]     num_vectors,
    input  logic                          pe_valid,
    input  logic [P*ELEMENT_BITS-1:0]     pe_data_out,
    output logic                          pe_ready,
    output logic [2*FEATURE_BITS-1:0]     main_mem_address,
    output logic [ELEMENT_BITS-1:0]       main_mem_data_out,
    output logic                          main_mem_cs_out,
    output logic                          main_mem_we_out,
    output logic                          store_done
);
    localparam int AW = 2 * FEATURE_BITS;
    localparam int VW = P * ELEMENT_BITS;
    localparam int IW = $clog2(P);
    localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VEC, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [VW-1:0]           vec_q, vec_d;
    logic [AW-1:0]           next_addr_q, next_addr_d;
    logic [AW-1:0]           remaining_q, remaining_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [ELEMENT_BITS-1:0] data_q, data_d;
    logic                    cs_q, cs_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
`ifdef RESULT_WRITER_SKID_EN
    logic [VW-1:0]           skid_q, skid_d;
    logic                    skid_full_q, skid_full_d;
`endif

    logic                    accept;
    logic                    load_en;
    logic [VW-1:0]           load_vec;

    function automatic logic [ELEMENT_BITS-1:0] elem(input logic [VW-1:0] v, input logic [IW-1:0] i);
        return v[i*ELEMENT_BITS +: ELEMENT_BITS];
    endfunction

    assign accept = pe_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_d       = vec_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cs_d        = 1'b0;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        load_en     = 1'b0;
        load_vec    = '0;
`ifdef RESULT_WRITER_SKID_EN
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    next_addr_d = base_address;
                    remaining_d = num_vectors;
                    if (num_vectors != '0) begin
                        state_d = WAIT_VEC;
                        ready_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_VEC: begin
                if (accept) begin
                    remaining_d = remaining_q - 1'b1;
                    load_en     = 1'b1;
                    load_vec    = pe_data_out;
                end else begin
                    ready_d = 1'b1;
                end
            end
            WRITE: begin
                if (idx_q != LAST_IDX) begin
                    idx_d       = idx_q + 1'b1;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + 1'b1;
                    data_d      = elem(vec_q, idx_q + 1'b1);
                    cs_d        = 1'b1;
`ifdef RESULT_WRITER_SKID_EN
                    if (accept) begin
                        skid_d      = pe_data_out;
                        skid_full_d = 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end
`endif
                end
`ifdef RESULT_WRITER_SKID_EN
                else if (skid_full_q) begin
                    load_en     = 1'b1;
                    load_vec    = skid_q;
                    skid_full_d = 1'b0;
                end else if (accept) begin
                    // Skid empty but a vector arrived on the last element: go straight to the write buffer.
                    load_en     = 1'b1;
                    load_vec    = pe_data_out;
                    remaining_d = remaining_q - 1'b1;
                end
`endif
                else if (remaining_q != '0) begin
                    state_d = WAIT_VEC;
                    ready_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // Entered with the pulse already raised from WRITE, or without it from an empty job.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            state_d     = WRITE;
            vec_d       = load_vec;
            idx_d       = '0;
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            data_d      = elem(load_vec, '0);
            cs_d        = 1'b1;
        end

`ifdef RESULT_WRITER_SKID_EN
        if (state_d == WRITE) begin
            ready_d = !skid_full_d && (remaining_d != '0);
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vec_q       <= '0;
            next_addr_q <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cs_q        <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef RESULT_WRITER_SKID_EN
            skid_q      <= '0;
            skid_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_q       <= vec_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cs_q        <= cs_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
`ifdef RESULT_WRITER_SKID_EN
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
`endif
        end
    end

    assign pe_ready          = ready_q;
    assign main_mem_address  = addr_q;
    assign main_mem_data_out = data_q;
    assign main_mem_cs_out   = cs_q;
    assign main_mem_we_out   = cs_q;
    assign store_done        = done_q;

endmodule

// File: tb/tb_pe_result_writer.sv
// Self-checking bench for pe_result_writer: directed scenarios plus randomized jobs scored against a write-timeline model.
module tb_pe_result_writer;
    localparam int FB = 4;
    localparam int EB = 8;
    localparam int P  = 4;
    localparam int AW = 2 * FB;
    localparam int VW = P * EB;
`ifdef RESULT_WRITER_SKID_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pe_valid = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] num_vectors = '0;
    logic [VW-1:0] pe_data_out = '0;
    logic          pe_ready;
    logic [AW-1:0] main_mem_address;
    logic [EB-1:0] main_mem_data_out;
    logic          main_mem_cs_out;
    logic          main_mem_we_out;
    logic          store_done;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  ready_cnt = 0;
    int  ready_in_write = 0;
    int  we_bad = 0;
    wr_t wr_log[$];
    int  hs_log[$];
    int  done_log[$];
    wr_t mon_w;
    bit  rst_got;

    pe_result_writer #(
        .FEATURE_BITS(FB),
        .ELEMENT_BITS(EB),
        .P(P)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .start(start),
        .base_address(base_address),
        .num_vectors(num_vectors),
        .pe_valid(pe_valid),
        .pe_data_out(pe_data_out),
        .pe_ready(pe_ready),
        .main_mem_address(main_mem_address),
        .main_mem_data_out(main_mem_data_out),
        .main_mem_cs_out(main_mem_cs_out),
        .main_mem_we_out(main_mem_we_out),
        .store_done(store_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Observation point: falling edge, inputs change at rising edge + 1.
    always @(negedge sys_clk) begin
        cyc++;
        if (main_mem_cs_out) begin
            mon_w.c = cyc;
            mon_w.a = main_mem_address;
            mon_w.d = main_mem_data_out;
            wr_log.push_back(mon_w);
        end
        if (pe_valid && pe_ready) hs_log.push_back(cyc);
        if (store_done) done_log.push_back(cyc);
        if (start) start_cyc = cyc;
        if (pe_ready) ready_cnt++;
        if (pe_ready && main_mem_cs_out) ready_in_write++;
        if (main_mem_we_out !== main_mem_cs_out) we_bad++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        hs_log.delete();
        done_log.delete();
        ready_cnt = 0;
        ready_in_write = 0;
        we_bad = 0;
    endtask

    task automatic run_job(input logic [7:0] base, input logic [7:0] num, input int max_delay,
                           input bit busy_stall, input bit fixed_en, input logic [31:0] fixed_vec);
        logic [31:0] vecs[$];
        logic [31:0] tv;
        wr_t         exp_q[$];
        wr_t         e;
        int          s;
        int          last;
        int          job_start;
        bit          got;
        bit          timeout;

        clear_logs();
        for (int v = 0; v < int'(num); v++) vecs.push_back((v == 0 && fixed_en) ? fixed_vec : $urandom);
        base_address = base;
        num_vectors  = num;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        job_start = start_cyc;

        if (busy_stall) begin
            tick(10);
            base_address = base + 8'h40;
            num_vectors  = num + 8'd3;
            start = 1'b1;
            tick(1);
            start = 1'b0;
            tick(9);
            check_eq("stall_no_write", wr_log.size(), 0);
            check_eq("stall_ready", pe_ready, 1);
            check_eq("stall_no_done", done_log.size(), 0);
        end

        timeout = 1'b0;
        for (int v = 0; v < int'(num); v++) begin
            pe_valid = 1'b0;
            tick($urandom_range(max_delay, 0));
            pe_valid = 1'b1;
            pe_data_out = vecs[v];
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge sys_clk);
                got = pe_ready;
                @(posedge sys_clk);
                #1;
            end
            if (!got) timeout = 1'b1;
        end
        pe_valid = 1'b0;
        pe_data_out = $urandom;
        for (int k = 0; k < 100 && done_log.size() == 0; k++) tick(1);
        tick(4);
        if (done_log.size() == 0) timeout = 1'b1;
        check_eq("job_timeout", timeout, 0);

        // Reference timeline: each vector writes P consecutive elements at consecutive addresses,
        // starting the cycle after its handshake (or right after the previous vector when buffered).
        last = -100;
        check_eq("hs_count", hs_log.size(), num);
        if (hs_log.size() == int'(num)) begin
            for (int v = 0; v < int'(num); v++) begin
                s = hs_log[v] + 1;
`ifdef RESULT_WRITER_SKID_EN
                if (s <= last) s = last + 1;
`endif
                tv = vecs[v];
                for (int j = 0; j < P; j++) begin
                    e.c = s + j;
                    e.a = 8'(int'(base) + v * P + j);
                    e.d = tv[j*8 +: 8];
                    exp_q.push_back(e);
                end
                last = s + P - 1;
            end
        end
        check_eq("wr_count", wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check_eq($sformatf("wr%0d_cyc_addr_data", i),
                     {wr_log[i].c, wr_log[i].a, wr_log[i].d}, {exp_q[i].c, exp_q[i].a, exp_q[i].d});

        check_eq("done_count", done_log.size(), 1);
        if (done_log.size() > 0)
            check_eq("done_cycle", done_log[0], (num == 0) ? job_start + 2 : last + 1);
        check_eq("we_eq_cs", we_bad, 0);
`ifndef RESULT_WRITER_SKID_EN
        check_eq("ready_in_write", ready_in_write, 0);
`endif

        if (num == 0) begin
            check_eq("empty_job_ready", ready_cnt, 0);
        end else begin
            if (max_delay == 0 && !busy_stall && hs_log.size() > 0)
                check_eq("first_ready", hs_log[0], job_start + 1);
            if (max_delay == 0 && !busy_stall && wr_log.size() == exp_q.size())
                for (int v = 1; v < int'(num); v++)
                    check_eq("vec_gap", wr_log[v*P].c - wr_log[v*P-1].c, GAP);
            if (exp_q.size() > 0)
                check_eq("hold_after_job", {main_mem_cs_out, main_mem_address, main_mem_data_out},
                         {1'b0, exp_q[exp_q.size()-1].a, exp_q[exp_q.size()-1].d});
            check_eq("ready_after_job", pe_ready, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_eq("idle_outs", {pe_ready, main_mem_address, main_mem_data_out,
                                   main_mem_cs_out, main_mem_we_out, store_done}, 0);
        end
        @(posedge sys_clk);
        #1;

        run_job(8'h10, 8'd1, 0, 1'b0, 1'b1, 32'h04030201);
        run_job(8'hFE, 8'd2, 0, 1'b0, 1'b0, 32'h0);
        run_job(8'h33, 8'd0, 0, 1'b0, 1'b0, 32'h0);
        run_job(8'h40, 8'd1, 0, 1'b1, 1'b0, 32'h0);

        // Reset while element 2 of the first vector is on the bus.
        clear_logs();
        base_address = 8'h20;
        num_vectors  = 8'd2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        pe_valid = 1'b1;
        pe_data_out = $urandom;
        rst_got = 1'b0;
        for (int k = 0; k < 50 && !rst_got; k++) begin
            @(negedge sys_clk);
            rst_got = pe_ready;
            @(posedge sys_clk);
            #1;
        end
        pe_valid = 1'b0;
        check_eq("rst_hs", rst_got, 1);
        tick(2);
        check_eq("rst_elem2_bus", {main_mem_cs_out, main_mem_address}, {1'b1, 8'h22});
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge sys_clk);
        check_eq("rst_outs", {pe_ready, main_mem_address, main_mem_data_out,
                              main_mem_cs_out, main_mem_we_out, store_done}, 0);
        @(posedge sys_clk);
        #1;
        tick(10);
        check_eq("rst_no_done", done_log.size(), 0);
        check_eq("rst_writes", wr_log.size(), 3);
        run_job(8'h20, 8'd2, 0, 1'b0, 1'b0, 32'h0);

        for (int r = 0; r < 8; r++)
            run_job(8'($urandom), 8'($urandom_range(4, 1)), $urandom_range(3, 0), 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_result_writer.md
Name: pe_result_writer

Overview:
- Write-back end of the main-memory interface. The weight loader reads elements one at a time from main memory into the PEs; this block takes P-element result vectors from the PE array and writes them back one element per cycle.
- Sits between the systolic array output and the main-memory write port, in the sys_clk domain.
- Handles the per-vector valid/ready handshake, P-to-1 serialization, sequential address generation and the completion pulse.

Parameters:
- FEATURE_BITS, 4, log2 of matrix dimension; the address is 2*FEATURE_BITS wide.
- ELEMENT_BITS, 8, width of one element.
- P, 4, elements per PE result vector (P >= 2).

Ports:
- sys_clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a store job (sampled only in IDLE).
- base_address  input  2*FEATURE_BITS  first write address; latched on accepted start.
- num_vectors  input  2*FEATURE_BITS  number of vectors in the job; latched on accepted start.
- pe_valid  input  1  PE vector available.
- pe_data_out  input  P*ELEMENT_BITS  result vector; element j occupies bits [j*ELEMENT_BITS +: ELEMENT_BITS].
- pe_ready  output  1  writer accepts a vector this cycle.
- main_mem_address  output  2*FEATURE_BITS  write address.
- main_mem_data_out  output  ELEMENT_BITS  write data.
- main_mem_cs_out  output  1  chip select.
- main_mem_we_out  output  1  write enable; equals main_mem_cs_out.
- store_done  output  1  one-cycle pulse when the job completes.

Behaviour:
- Reset: state=IDLE, pe_ready=0, main_mem_address=0, main_mem_data_out=0, cs=0, we=0, store_done=0, internal counters and buffer cleared. Reset takes priority at any cycle, including mid-WRITE; a partially written vector is abandoned and no store_done is produced.
- FSM states: IDLE, WAIT_VEC, WRITE, DONE.
- IDLE:
  - pe_ready=0.
  - start=1 latches base_address into the address counter and num_vectors into the remaining counter.
  - Next state is WAIT_VEC if num_vectors!=0, otherwise DONE.
- WAIT_VEC:
  - pe_ready=1.
  - On pe_valid&pe_ready: capture pe_data_out, decrement remaining, go to WRITE.
  - pe_valid=0 simply holds; there is no timeout.
- WRITE:
  - Outputs are registered. The cycle after the handshake, the outputs present element 0 at the current address with cs=we=1.
  - Each following cycle presents element j+1 at address+1.
  - P consecutive write cycles per vector.
  - pe_ready=0 (base build).
- End of vector, after the element P-1 cycle:
  - remaining!=0 goes to WAIT_VEC, with cs=we=0 in that cycle.
  - remaining==0 goes to DONE.
- DONE: store_done=1 for exactly one cycle, cs=0, then IDLE.
- Address arithmetic: increments by 1 per element, modulo 2^(2*FEATURE_BITS); wraps from all-ones to 0 silently.
- main_mem_data_out and main_mem_address hold their last value when cs=0.
- start outside IDLE is ignored, with no effect on the latched job.
- pe_data_out changes after the handshake do not affect the vector being written.
- Throughput (base build): one vector per P+1 cycles minimum, because the WAIT_VEC cycle between vectors is a bubble.

Optional Feature:
- Macro: RESULT_WRITER_SKID_EN.
- Defined:
  - Adds one skid vector buffer.
  - In WRITE, pe_ready = !skid_full && (remaining beyond the current vector != 0).
  - A vector accepted during WRITE is loaded directly after element P-1, so element 0 of the next vector follows with no cs gap.
  - Sustained throughput is one element per cycle.
  - The skid buffer is cleared by reset.
- Undefined: behaviour exactly as above, with pe_ready=0 throughout WRITE.

Test Plan:
- Reset, then idle: all outputs 0 and pe_ready=0 for 10 cycles; start=0 throughout.
- Single vector, base_address=0x10, num_vectors=1, pe_data_out=0x04030201:
  - Writes 0x01@0x10, 0x02@0x11, 0x03@0x12, 0x04@0x13 on 4 consecutive cycles with cs=we=1.
  - store_done pulses once, in the cycle after the last write.
- Wrap: base_address=0xFE, num_vectors=2 → addresses 0xFE, 0xFF, 0x00 … 0x05; store_done after 8 writes; 1-cycle cs gap between the vectors (base build), no gap with RESULT_WRITER_SKID_EN.
- num_vectors=0 with start → store_done pulses 2 cycles after start; no cs assertion; pe_ready never 1.
- Stall and busy-start: pe_valid held low for 20 cycles in WAIT_VEC with start pulsed meanwhile → outputs idle, job unchanged; then pe_valid=1 → normal writes resume at the correct address.
- Reset asserted during the element-2 write cycle → next cycle all outputs 0 and state IDLE; no store_done; a new job then completes normally.
